// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared types and helpers for the byte-serial memory port controller.
//   state_e      - controller FSM states
//   LEN_B/H/W    - legal byte-count encodings (1, 2, 4)
//   IO_SEL_DEF   - default addr[17:16] value that marks an IO access
//   is_io()      - IO address decode
//   norm_len()   - maps any len onto 1/2/4 (illegal values become a word)
//   extend_rdata - sign/zero extension of assembled read data
package mem_port_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdLast,
        StWr,
        StDone
    } state_e;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    localparam logic [1:0] IO_SEL_DEF = 2'b11;

    // Caller passes addr[17:16] and the IO selector in force.
    function automatic logic is_io(input logic [1:0] addr_hi, input logic [1:0] io_sel);
        return addr_hi == io_sel;
    endfunction

    function automatic logic [2:0] norm_len(input logic [2:0] len);
        logic [2:0] l;
        case (len)
            LEN_B:   l = LEN_B;
            LEN_H:   l = LEN_H;
            default: l = LEN_W;
        endcase
        return l;
    endfunction

    function automatic logic [31:0] extend_rdata(input logic [31:0] raw, input logic [2:0] len,
                                                 input logic sgn);
        logic [31:0] r;
        case (len)
            LEN_B:   r = {{24{sgn & raw[7]}}, raw[7:0]};
            LEN_H:   r = {{16{sgn & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: request channels plus external byte bus of mem_port_ctrl.
// Per-port signals are flattened; port p occupies slice p.
//   master - controller view (serves requests, drives the external bus)
//   slave  - environment view (requesters and RAM/IO)
interface mem_port_ctrl_if #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32
);
    logic                        rdy;
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*32-1:0]     wdata;
    logic [NUM_PORTS*3-1:0]      len;
    logic [NUM_PORTS-1:0]        sgn;
    logic [NUM_PORTS-1:0]        abort;
    logic [NUM_PORTS-1:0]        done;
    logic [31:0]                 rdata;
    logic                        busy;
    logic [7:0]                  mem_din;
    logic                        io_buffer_full;
    logic [7:0]                  mem_dout;
    logic [31:0]                 mem_a;
    logic                        mem_wr;

    modport master (
        input  rdy, req, we, addr, wdata, len, sgn, abort, mem_din, io_buffer_full,
        output done, rdata, busy, mem_dout, mem_a, mem_wr
    );

    modport slave (
        output rdy, req, we, addr, wdata, len, sgn, abort, mem_din, io_buffer_full,
        input  done, rdata, busy, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb: combinational request arbiter, one-hot grant out.
//   req_i  - request vector
//   last_i - index of the previous grant (round-robin start point)
//   gnt_o  - one-hot grant, zero when no request
// MEM_PORT_RR_EN defined: round-robin starting at last_i + 1.
// Otherwise fixed priority, lowest index wins.
module mem_port_arb #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned GW        = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [GW-1:0]        last_i,
    output logic [NUM_PORTS-1:0] gnt_o
);
`ifdef MEM_PORT_RR_EN
    always_comb begin
        int unsigned idx;
        idx   = 0;
        gnt_o = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = (32'(last_i) + k) % NUM_PORTS;
            if (gnt_o == '0 && req_i[idx]) gnt_o[idx] = 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last_i;

    // Walk downwards so the lowest requesting index is the final winner.
    always_comb begin
        gnt_o = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: arbitrates NUM_PORTS request channels onto one 8-bit RAM/IO bus,
// serialising 1/2/4-byte reads and writes little-endian.
//   clk - clock
//   rst - synchronous active-low reset
//   bus - mem_port_ctrl_if.master: requests, done/rdata/busy, external byte bus,
//         rdy pause and io_buffer_full back-pressure
// MEM_PORT_RR_EN selects round-robin arbitration (see mem_port_arb).
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter logic [1:0]  IO_SEL    = IO_SEL_DEF
) (
    input logic              clk,
    input logic              rst,
    mem_port_ctrl_if.master  bus
);
    localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_e              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [2:0]          len_q, len_d;
    logic                sgn_q, sgn_d;
    logic                we_q, we_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [31:0]         rbuf_q;
    // cap_q: the previous cycle issued a read address, so mem_din holds its byte now.
    logic                cap_q, cap_d;
    logic [1:0]          lane_q, lane_d;

    logic [NUM_PORTS-1:0] gnt;
    logic [GW-1:0]        gnt_idx;
    logic [ADDR_W-1:0]    sel_addr, cur_addr;
    logic [31:0]          sel_wdata;
    logic [2:0]           sel_len;
    logic                 sel_sgn, sel_we;
    logic                 abort_hit, io_stall, last_byte;

    mem_port_arb #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_arb (
        .req_i  (bus.req),
        .last_i (grant_q),
        .gnt_o  (gnt)
    );

    always_comb begin
        gnt_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_len   = '0;
        sel_sgn   = 1'b0;
        sel_we    = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                gnt_idx   = GW'(p);
                sel_addr  = bus.addr[p*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata[p*32 +: 32];
                sel_len   = bus.len[p*3 +: 3];
                sel_sgn   = bus.sgn[p];
                sel_we    = bus.we[p];
            end
        end
    end

    assign cur_addr  = addr_q + ADDR_W'(cnt_q);
    assign last_byte = (cnt_q == len_q - 3'd1);
    assign io_stall  = we_q && is_io(cur_addr[17:16], IO_SEL) && bus.io_buffer_full;
    // Writes never abort; a stray abort on another port is ignored.
    assign abort_hit = bus.abort[grant_q] &&
                       (state_q == StRd || state_q == StRdLast || state_q == StDone);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        len_d        = len_q;
        sgn_d        = sgn_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        cap_d        = 1'b0;
        lane_d       = cnt_q[1:0];
        bus.done     = '0;
        bus.rdata    = '0;
        bus.mem_a    = '0;
        bus.mem_dout = '0;
        bus.mem_wr   = 1'b0;
        bus.busy     = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (bus.rdy && (|bus.req)) begin
                    grant_d = gnt_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    len_d   = norm_len(sel_len);
                    sgn_d   = sel_sgn;
                    we_d    = sel_we;
                    cnt_d   = '0;
                    state_d = sel_we ? StWr : StRd;
                end
            end
            StRd: begin
                bus.mem_a = 32'(cur_addr);
                if (abort_hit) begin
                    state_d = StIdle;
                end else if (bus.rdy) begin
                    cap_d = 1'b1;
                    if (last_byte) state_d = StRdLast;
                    else           cnt_d   = cnt_q + 3'd1;
                end
            end
            StRdLast: begin
                if (abort_hit)    state_d = StIdle;
                else if (bus.rdy) state_d = StDone;
            end
            StWr: begin
                bus.mem_a    = 32'(cur_addr);
                bus.mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (bus.rdy && !io_stall) begin
                    bus.mem_wr = 1'b1;
                    if (last_byte) state_d = StDone;
                    else           cnt_d   = cnt_q + 3'd1;
                end
            end
            StDone: begin
                if (abort_hit) begin
                    state_d = StIdle;
                end else begin
                    if (!we_q) bus.rdata = extend_rdata(rbuf_q, len_q, sgn_q);
                    // Pulse only on the cycle the FSM actually leaves, so a pause
                    // cannot stretch done.
                    if (bus.rdy) begin
                        bus.done[grant_q] = 1'b1;
                        state_d           = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            cap_q   <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            sgn_q   <= sgn_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            lane_q  <= lane_d;
            // The byte lands regardless of the current rdy; only its address cycle matters.
            if (cap_q) rbuf_q[{lane_q, 3'b000} +: 8] <= bus.mem_din;
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
module tb_mem_port_ctrl;
    localparam int unsigned NP = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0]  ram      [0:1023];
    logic [31:0] a_log    [0:31];
    logic        wr_log   [0:31];
    logic [7:0]  dout_log [0:31];
    logic        busy_log [0:31];
    int          done_cyc;
    logic [31:0] rd_val;
    logic        stray;

    mem_port_ctrl_if #(.NUM_PORTS(NP), .ADDR_W(32)) bus ();

    mem_port_ctrl #(
        .NUM_PORTS (NP),
        .ADDR_W    (32),
        .IO_SEL    (2'b11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM returns the byte one cycle after its address.
    always @(posedge clk) bus.mem_din <= ram[bus.mem_a[9:0]];

    task automatic idle_inputs();
        bus.req            = '0;
        bus.we             = '0;
        bus.sgn            = '0;
        bus.abort          = '0;
        bus.addr           = '0;
        bus.wdata          = '0;
        bus.len            = '0;
        bus.rdy            = 1'b1;
        bus.io_buffer_full = 1'b0;
    endtask

    // Single transaction on one port; starts and ends at posedge+1 with the DUT idle.
    task automatic do_txn(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] len, input logic sgn,
                          input int rdy_lo, input int rdy_hi, input int full_lo,
                          input int full_hi, input int abort_at);
        logic [NP-1:0] others;
        done_cyc = -1;
        rd_val   = '0;
        stray    = 1'b0;
        bus.req[port]             = 1'b1;
        bus.we[port]              = we;
        bus.addr[port*32 +: 32]   = addr;
        bus.wdata[port*32 +: 32]  = wdata;
        bus.len[port*3 +: 3]      = len;
        bus.sgn[port]             = sgn;
        for (int k = 0; k < 32; k++) begin
            bus.rdy            = !(k >= rdy_lo && k <= rdy_hi);
            bus.io_buffer_full = (k >= full_lo && k <= full_hi);
            bus.abort[port]    = (k == abort_at);
            @(negedge clk);
            a_log[k]    = bus.mem_a;
            wr_log[k]   = bus.mem_wr;
            dout_log[k] = bus.mem_dout;
            busy_log[k] = bus.busy;
            others       = bus.done;
            others[port] = 1'b0;
            if (others != '0) stray = 1'b1;
            if (bus.done[port] && done_cyc < 0) begin
                done_cyc = k;
                rd_val   = bus.rdata;
            end
            @(posedge clk);
            #1;
            if (done_cyc >= 0) break;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%h exp=0", bus.busy); end
        checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL reset_done got=%h exp=0", bus.done); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
        checks++; if (bus.mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", bus.mem_a); end
        checks++; if (bus.mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%h exp=0", bus.mem_wr); end
        checks++; if (bus.mem_dout !== 8'h0) begin failures++; $display("FAIL reset_mem_dout got=%h exp=0", bus.mem_dout); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_word();
        do_txn(1, 1'b0, 32'h100, 32'h0, 3'd4, 1'b0, -1, -1, -1, -1, -1);
        checks++; if (done_cyc !== 6) begin failures++; $display("FAIL rd4_done_cycle got=%0d exp=6", done_cyc); end
        checks++; if (rd_val !== 32'h44332211) begin failures++; $display("FAIL rd4_rdata got=%h exp=44332211", rd_val); end
        checks++; if (stray !== 1'b0) begin failures++; $display("FAIL rd4_stray_done got=%h exp=0", stray); end
        checks++; if (busy_log[0] !== 1'b0) begin failures++; $display("FAIL rd4_busy_c0 got=%h exp=0", busy_log[0]); end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (a_log[k] !== 32'h100 + 32'(k - 1)) begin
                failures++; $display("FAIL rd4_mem_a_c%0d got=%h exp=%h", k, a_log[k], 32'h100 + 32'(k - 1));
            end
            checks++;
            if (wr_log[k] !== 1'b0) begin failures++; $display("FAIL rd4_mem_wr_c%0d got=%h exp=0", k, wr_log[k]); end
        end
    endtask

    task automatic test_sign_ext();
        do_txn(0, 1'b0, 32'h180, 32'h0, 3'd1, 1'b1, -1, -1, -1, -1, -1);
        checks++; if (done_cyc !== 3) begin failures++; $display("FAIL sx_b_done_cycle got=%0d exp=3", done_cyc); end
        checks++; if (rd_val !== 32'hFFFFFF80) begin failures++; $display("FAIL sx_b_sgn got=%h exp=ffffff80", rd_val); end
        do_txn(1, 1'b0, 32'h180, 32'h0, 3'd1, 1'b0, -1, -1, -1, -1, -1);
        checks++; if (rd_val !== 32'h00000080) begin failures++; $display("FAIL sx_b_zero got=%h exp=00000080", rd_val); end
        do_txn(0, 1'b0, 32'h190, 32'h0, 3'd2, 1'b1, -1, -1, -1, -1, -1);
        checks++; if (done_cyc !== 4) begin failures++; $display("FAIL sx_h_done_cycle got=%0d exp=4", done_cyc); end
        checks++; if (rd_val !== 32'hFFFF9234) begin failures++; $display("FAIL sx_h_sgn got=%h exp=ffff9234", rd_val); end
        // len 3 is illegal and behaves as a word.
        do_txn(1, 1'b0, 32'h100, 32'h0, 3'd3, 1'b1, -1, -1, -1, -1, -1);
        checks++; if (done_cyc !== 6) begin failures++; $display("FAIL len3_done_cycle got=%0d exp=6", done_cyc); end
        checks++; if (rd_val !== 32'h44332211) begin failures++; $display("FAIL len3_rdata got=%h exp=44332211", rd_val); end
    endtask

    task automatic test_io_write();
        logic [31:0] w;
        // abort during a write must be ignored.
        do_txn(0, 1'b1, 32'h30000, 32'h41, 3'd1, 1'b0, -1, -1, 1, 3, 2);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (wr_log[k] !== 1'b0) begin failures++; $display("FAIL io_stall_wr_c%0d got=%h exp=0", k, wr_log[k]); end
        end
        checks++; if (wr_log[4] !== 1'b1) begin failures++; $display("FAIL io_wr_c4 got=%h exp=1", wr_log[4]); end
        checks++; if (a_log[4] !== 32'h30000) begin failures++; $display("FAIL io_mem_a got=%h exp=30000", a_log[4]); end
        checks++; if (dout_log[4] !== 8'h41) begin failures++; $display("FAIL io_dout got=%h exp=41", dout_log[4]); end
        checks++; if (done_cyc !== 5) begin failures++; $display("FAIL io_done_cycle got=%0d exp=5", done_cyc); end
        // RAM address: io_buffer_full has no effect.
        w = 32'hDEADBEEF;
        do_txn(0, 1'b1, 32'h40, w, 3'd4, 1'b0, -1, -1, 0, 10, -1);
        checks++; if (done_cyc !== 5) begin failures++; $display("FAIL ramwr_done_cycle got=%0d exp=5", done_cyc); end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (wr_log[k] !== 1'b1 || dout_log[k] !== w[8*(k-1) +: 8] || a_log[k] !== 32'h40 + 32'(k - 1)) begin
                failures++;
                $display("FAIL ramwr_byte_c%0d got wr=%h dout=%h a=%h exp wr=1 dout=%h a=%h", k, wr_log[k],
                         dout_log[k], a_log[k], w[8*(k-1) +: 8], 32'h40 + 32'(k - 1));
            end
        end
    endtask

    task automatic test_priority();
        int d0;
        int d1;
        int exp_d0;
        int exp_d1;
        logic [31:0] exp_a5;
        logic [31:0] r1;
`ifdef MEM_PORT_RR_EN
        exp_d0 = 7; exp_d1 = 3; exp_a5 = 32'h180;
`else
        exp_d0 = 3; exp_d1 = 7; exp_a5 = 32'h100;
`endif
        d0 = -1; d1 = -1; r1 = '0;
        bus.req            = 2'b11;
        bus.addr[31:0]     = 32'h180;
        bus.addr[63:32]    = 32'h100;
        bus.len            = {3'd1, 3'd1};
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            a_log[k]    = bus.mem_a;
            busy_log[k] = bus.busy;
            if (bus.done[0] && d0 < 0) d0 = k;
            if (bus.done[1] && d1 < 0) begin d1 = k; r1 = bus.rdata; end
            @(posedge clk);
            #1;
            if (d0 >= 0) bus.req[0] = 1'b0;
            if (d1 >= 0) bus.req[1] = 1'b0;
            if (d0 >= 0 && d1 >= 0) break;
        end
        idle_inputs();
        checks++; if (d0 !== exp_d0) begin failures++; $display("FAIL arb_done0_cycle got=%0d exp=%0d", d0, exp_d0); end
        checks++; if (d1 !== exp_d1) begin failures++; $display("FAIL arb_done1_cycle got=%0d exp=%0d", d1, exp_d1); end
        checks++; if (a_log[5] !== exp_a5) begin failures++; $display("FAIL arb_second_addr got=%h exp=%h", a_log[5], exp_a5); end
        checks++; if (busy_log[4] !== 1'b0) begin failures++; $display("FAIL arb_idle_gap got=%h exp=0", busy_log[4]); end
        checks++; if (r1 !== 32'h11) begin failures++; $display("FAIL arb_rdata1 got=%h exp=00000011", r1); end
    endtask

    task automatic test_abort();
        int d0;
        int d1;
        logic [31:0] r1;
        d0 = -1; d1 = -1; r1 = '0;
        bus.req[0]      = 1'b1;
        bus.addr[31:0]  = 32'h100;
        bus.len[2:0]    = 3'd4;
        for (int k = 0; k < 20; k++) begin
            if (k == 1) begin
                bus.req[1]      = 1'b1;
                bus.addr[63:32] = 32'h180;
                bus.len[5:3]    = 3'd1;
                bus.sgn[1]      = 1'b1;
            end
            if (k == 3) bus.req[0] = 1'b0;
            // Cycle 2 aborts the granted port; cycle 5 aborts a non-granted one.
            bus.abort[0] = (k == 2 || k == 5);
            @(negedge clk);
            a_log[k]    = bus.mem_a;
            busy_log[k] = bus.busy;
            if (bus.done[0] && d0 < 0) d0 = k;
            if (bus.done[1] && d1 < 0) begin d1 = k; r1 = bus.rdata; end
            @(posedge clk);
            #1;
            if (d1 >= 0) break;
        end
        idle_inputs();
        checks++; if (busy_log[3] !== 1'b0) begin failures++; $display("FAIL abort_idle_c3 got=%h exp=0", busy_log[3]); end
        checks++; if (d0 !== -1) begin failures++; $display("FAIL abort_no_done0 got=%0d exp=-1", d0); end
        checks++; if (a_log[4] !== 32'h180) begin failures++; $display("FAIL abort_next_addr got=%h exp=180", a_log[4]); end
        checks++; if (d1 !== 6) begin failures++; $display("FAIL abort_done1_cycle got=%0d exp=6", d1); end
        checks++; if (r1 !== 32'hFFFFFF80) begin failures++; $display("FAIL abort_rdata1 got=%h exp=ffffff80", r1); end
    endtask

    task automatic test_rdy_pause();
        do_txn(1, 1'b0, 32'h200, 32'h0, 3'd4, 1'b0, 2, 3, -1, -1, -1);
        checks++; if (a_log[1] !== 32'h200) begin failures++; $display("FAIL pause_a_c1 got=%h exp=200", a_log[1]); end
        checks++; if (a_log[4] !== 32'h201) begin failures++; $display("FAIL pause_reissue_c4 got=%h exp=201", a_log[4]); end
        checks++; if (a_log[6] !== 32'h203) begin failures++; $display("FAIL pause_a_c6 got=%h exp=203", a_log[6]); end
        checks++; if (done_cyc !== 8) begin failures++; $display("FAIL pause_done_cycle got=%0d exp=8", done_cyc); end
        checks++; if (rd_val !== 32'hD4C3B2A1) begin failures++; $display("FAIL pause_rdata got=%h exp=d4c3b2a1", rd_val); end
        // Write with rdy low in cycle 1: mem_wr forced low, byte 0 re-driven in cycle 2.
        do_txn(0, 1'b1, 32'h50, 32'h0000BBAA, 3'd2, 1'b0, 1, 1, -1, -1, -1);
        checks++; if (wr_log[1] !== 1'b0) begin failures++; $display("FAIL pause_wr_c1 got=%h exp=0", wr_log[1]); end
        checks++;
        if (wr_log[2] !== 1'b1 || dout_log[2] !== 8'hAA) begin
            failures++; $display("FAIL pause_wr_c2 got wr=%h dout=%h exp wr=1 dout=aa", wr_log[2], dout_log[2]);
        end
        checks++;
        if (wr_log[3] !== 1'b1 || dout_log[3] !== 8'hBB) begin
            failures++; $display("FAIL pause_wr_c3 got wr=%h dout=%h exp wr=1 dout=bb", wr_log[3], dout_log[3]);
        end
        checks++; if (done_cyc !== 4) begin failures++; $display("FAIL pause_wr_done got=%0d exp=4", done_cyc); end
    endtask

    task automatic test_addr_wrap();
        do_txn(1, 1'b0, 32'hFFFFFFFF, 32'h0, 3'd2, 1'b0, -1, -1, -1, -1, -1);
        checks++; if (a_log[1] !== 32'hFFFFFFFF) begin failures++; $display("FAIL wrap_a_c1 got=%h exp=ffffffff", a_log[1]); end
        checks++; if (a_log[2] !== 32'h0) begin failures++; $display("FAIL wrap_a_c2 got=%h exp=0", a_log[2]); end
        checks++; if (rd_val !== 32'h0000A55A) begin failures++; $display("FAIL wrap_rdata got=%h exp=0000a55a", rd_val); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h180] = 8'h80;
        ram[10'h190] = 8'h34; ram[10'h191] = 8'h92;
        ram[10'h200] = 8'hA1; ram[10'h201] = 8'hB2; ram[10'h202] = 8'hC3; ram[10'h203] = 8'hD4;
        ram[10'h3FF] = 8'h5A; ram[10'h000] = 8'hA5;
        idle_inputs();
        test_reset();
        test_read_word();
        test_sign_ext();
        test_io_write();
        test_priority();
        test_abort();
        test_rdy_pause();
        test_addr_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
